// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, source encodings and FSM state type for the writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int RF_BUS_W   = 38;
    localparam int PC_W       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_DIV  = 1'b1;

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        DIV_FORCE = 1'b1
    } wbarb_state_e;

    // r0 is hard-wired zero, so a divider result aimed at it must not write.
    function automatic logic div_we(input logic [REG_ADDR_W-1:0] waddr);
        return (waddr != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wbarb_starve_ctr.sv
// Starvation guard: counts cycles a divider result waits and forces its grant at STARVE_LIMIT.
module wbarb_starve_ctr
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic div_valid,
    input  logic div_ready,
    output logic force_div
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;
    wbarb_state_e     state_r;
    wbarb_state_e     state_s;

    // Next counter value: saturating wait count, cleared on handshake or idle divider.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!div_valid || div_ready) begin
            starve_cnt_s = {CNT_W{1'b0}};
        end else if (starve_cnt_r != LIMIT) begin
            starve_cnt_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Next state: force the divider once the wait count reaches the limit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            PIPE_PRI: begin
                if (starve_cnt_s == LIMIT) state_s = DIV_FORCE;
                else                       state_s = PIPE_PRI;
            end
            DIV_FORCE: begin
                if (!div_valid || div_ready) state_s = PIPE_PRI;
                else                         state_s = DIV_FORCE;
            end
            default: state_s = PIPE_PRI;
        endcase
    end

    // Counter and state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
            state_r      <= PIPE_PRI;
        end else begin
            starve_cnt_r <= starve_cnt_s;
            state_r      <= state_s;
        end
    end

    assign force_div = (state_r == DIV_FORCE);

endmodule

// File: rtl/wb_port_arbiter.sv
// Registered writeback stage sharing the regfile write port between pipeline and divider.
// Macro WBARB_STARVE_GUARD_EN enables the divider starvation guard; otherwise strict pipeline priority.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic [RF_BUS_W-1:0]   pipe_rf_bus,
    input  logic [PC_W-1:0]       pipe_pc,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic [REG_ADDR_W-1:0] div_waddr,
    input  logic [DATA_W-1:0]     div_wdata,
    input  logic [PC_W-1:0]       div_pc,
    output logic [RF_BUS_W-1:0]   rf_bus,
    output logic                  out_src,
    output logic [PC_W-1:0]       debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [REG_ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata
);

    logic                  grant_div_s;
    logic                  force_div_s;
    logic                  out_valid_r;
    logic                  we_r;
    logic                  src_r;
    logic [REG_ADDR_W-1:0] waddr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [PC_W-1:0]       pc_r;

`ifdef WBARB_STARVE_GUARD_EN
    wbarb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .div_valid (div_valid),
        .div_ready (grant_div_s),
        .force_div (force_div_s)
    );
`else
    // Strict pipeline priority; the limit has no effect in this build.
    assign force_div_s = 1'b0 & (STARVE_LIMIT != 0);
`endif

    // Grant: pipeline wins unless it is idle or the divider is being forced.
    always_comb begin
        grant_div_s = div_valid & (~pipe_valid | force_div_s);
        pipe_ready  = ~grant_div_s;
        div_ready   = grant_div_s;
    end

    // Writeback register: latch the granted entry, drop valid when nothing handshakes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            we_r        <= 1'b0;
            waddr_r     <= {REG_ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            pc_r        <= {PC_W{1'b0}};
            src_r       <= SRC_PIPE;
        end else if (div_valid && grant_div_s) begin
            out_valid_r <= 1'b1;
            we_r        <= div_we(div_waddr);
            waddr_r     <= div_waddr;
            wdata_r     <= div_wdata;
            pc_r        <= div_pc;
            src_r       <= SRC_DIV;
        end else if (pipe_valid && !grant_div_s) begin
            out_valid_r <= 1'b1;
            {we_r, waddr_r, wdata_r} <= pipe_rf_bus;
            pc_r        <= pipe_pc;
            src_r       <= SRC_PIPE;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign rf_bus            = {we_r & out_valid_r, waddr_r, wdata_r};
    assign out_src           = src_r;
    assign debug_wb_pc       = pc_r;
    assign debug_wb_rf_we    = {4{we_r & out_valid_r}};
    assign debug_wb_rf_wnum  = waddr_r;
    assign debug_wb_rf_wdata = wdata_r;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order MEM→WB pipeline stream and the long-latency divider completion path.
- Registered writeback stage: grants one requester per cycle, latches its write, drives the regfile bus and trace debug interface.
- Pipeline has default priority; starvation guard forces divider grant after a bounded wait.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a valid, ungranted divider request may wait before a forced grant (≥1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pipe_valid  in  1  MEM stage holds a retiring instruction
- pipe_ready  out  1  arbiter accepts pipeline entry this cycle
- pipe_rf_bus  in  38  {we, waddr[4:0], wdata[31:0]}
- pipe_pc  in  32  PC of pipeline entry
- div_valid  in  1  divider result pending
- div_ready  out  1  arbiter accepts divider result this cycle
- div_waddr  in  5  divider destination register
- div_wdata  in  32  divider result
- div_pc  in  32  PC of divide instruction
- rf_bus  out  38  {we & out_valid, waddr, wdata} to regfile/ID forwarding
- out_src  out  1  0 = pipeline, 1 = divider (registered grant source)
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_we  out  4  {4{we & out_valid}}
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset (async, resetn=0): out_valid, we, waddr, wdata, pc, out_src, starve_cnt = 0; FSM = PIPE_PRI. All outputs 0, pipe_ready/div_ready follow comb rules (out stage always ready).
- Output stage ready_go = 1: accepts one entry every cycle; latency 1 cycle from handshake to rf_bus/debug.
- Grant (combinational): grant_div = div_valid & (~pipe_valid | state==DIV_FORCE). pipe_ready = ~grant_div; div_ready = grant_div. Never both ready-and-valid in same cycle.
- Latch on posedge: pipe_valid & pipe_ready → {we,waddr,wdata}=pipe_rf_bus, pc=pipe_pc, out_src=0, out_valid=1. div handshake → we=(div_waddr!=0), waddr, wdata, pc=div_pc, out_src=1, out_valid=1. No handshake → out_valid=0, data regs hold.
- Pipeline entries with we=0 still occupy a slot and produce debug_wb_pc; debug_wb_rf_we = 0.
- Divider write to r0: we forced 0; pipeline r0 writes pass through unchanged (decoder handles).
- FSM: PIPE_PRI → DIV_FORCE when starve_cnt reaches STARVE_LIMIT; DIV_FORCE → PIPE_PRI on divider handshake. DIV_FORCE with div_valid dropped (not permitted by protocol) → return to PIPE_PRI, counter clears.
- starve_cnt width $clog2(STARVE_LIMIT+1); increments when div_valid & ~div_ready, saturates at STARVE_LIMIT; clears on div handshake or div_valid=0.
- Valid inputs must hold stable until ready; arbiter does not reorder WAW to same register (upstream issue logic guarantees).
- Reset mid-operation: in-flight latched write discarded (out_valid=0 immediately, asynchronously).

Optional Feature:
- WBARB_STARVE_GUARD_EN: defined → starvation counter and DIV_FORCE state as above. Undefined → strict pipeline priority, grant_div = div_valid & ~pipe_valid, no counter/FSM registers; STARVE_LIMIT ignored.

Decomposition:
- Shared package: RF_BUS_W=38, PC_W=32, REG_ADDR_W=5, src encodings SRC_PIPE=0/SRC_DIV=1, FSM state enum {PIPE_PRI, DIV_FORCE}.
- One natural sub-module: wbarb_starve_ctr (counter + FSM), instantiated only under WBARB_STARVE_GUARD_EN.

Test Plan:
- Reset: resetn low mid-run with out_valid=1 → rf_bus=0, debug_wb_rf_we=0 same cycle; all regs 0.
- Pipe only: pipe_rf_bus={1,5'd3,32'h1234}, pc=0x1c000000 → next cycle rf_bus we=1 waddr=3 wdata=0x1234, debug_wb_rf_we=4'hf, out_src=0.
- Div only, idle pipe: div_waddr=7, wdata=0xdead → div_ready=1 same cycle, next cycle write r7=0xdead, out_src=1; div_waddr=0 → we=0.
- Contention, STARVE_LIMIT=4, both valid continuously → pipe granted 4 cycles, 5th cycle div_ready=1, counter clears, pipe resumes next.
- Guard undefined, both valid 10 cycles → div_ready stays 0; granted first cycle pipe_valid=0.
- Pipe we=0 entry (branch) → debug_wb_pc updates, debug_wb_rf_we=0, rf_bus we=0.
